// File: rtl/zeroriscy_div_seq.sv
// Sequential radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU, borrowing the ALU adder.
// Latency: 34 cycles from start to valid_o (1 cycle for a fast divide-by-zero).
// Backpressure: none; a new start is accepted only while ready_o is high, i.e. in IDLE.
module zeroriscy_div_seq #(
    parameter int                    ZERO_DIV_FAST = 1,
    parameter int                    ALU_OP_WIDTH  = 6,
    parameter logic [ALU_OP_WIDTH-1:0] ALU_ADD     = ALU_OP_WIDTH'(24),
    parameter logic [ALU_OP_WIDTH-1:0] ALU_SUB     = ALU_OP_WIDTH'(25)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    div_en_i,
    input  logic [1:0]              div_op_i,
    input  logic [31:0]             op_a_i,
    input  logic [31:0]             op_b_i,
    input  logic                    kill_i,
    output logic                    ready_o,
    output logic                    valid_o,
    output logic [31:0]             result_o,
    output logic                    alu_req_o,
    output logic [ALU_OP_WIDTH-1:0] alu_operator_o,
    output logic [31:0]             alu_operand_a_o,
    output logic [31:0]             alu_operand_b_o,
    input  logic [31:0]             alu_adder_result_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] divisor_q, divisor_d;
    logic [31:0] dividend_q, dividend_d;
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q, neg_rem_d;
    logic        div_zero_q, div_zero_d;
    logic        ready_q, ready_d;
    logic        valid_q, valid_d;
    logic [31:0] result_q, result_d;

    logic        start_signed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic        b_is_zero;
    logic [31:0] shifted;
    logic        no_borrow;
    logic [31:0] quot_fixed;
    logic [31:0] rem_fixed;

    // Operand conditioning at start: magnitudes of the signed inputs and divide-by-zero detect
    always_comb begin
        start_signed = ~div_op_i[0];
        abs_a        = (start_signed && op_a_i[31]) ? (~op_a_i + 32'd1) : op_a_i;
        abs_b        = (start_signed && op_b_i[31]) ? (~op_b_i + 32'd1) : op_b_i;
        b_is_zero    = (op_b_i == 32'd0);
    end

    // One restoring step: shift in the next dividend bit and decide whether the subtract fits.
    // A set R[31] means the shifted value exceeds 2^32 > B, so the subtract is always taken
    // and the truncated adder result is still the exact new remainder.
    always_comb begin
        shifted = {rem_q[30:0], quot_q[31]};
        if (rem_q[31]) begin
            no_borrow = 1'b1;
        end else if (shifted[31] ^ divisor_q[31]) begin
            no_borrow = ~divisor_q[31];
        end else begin
            no_borrow = ~alu_adder_result_i[31];
        end
    end

    // Sign restoration of the magnitude results
    always_comb begin
        quot_fixed = neg_quot_q ? (~quot_q + 32'd1) : quot_q;
        rem_fixed  = neg_rem_q  ? (~rem_q  + 32'd1) : rem_q;
    end

    // ALU drive: the divider only owns the adder while iterating
    always_comb begin
        alu_req_o       = (state_q == CALC);
        alu_operator_o  = (state_q == CALC) ? ALU_SUB : ALU_ADD;
        alu_operand_a_o = (state_q == CALC) ? shifted   : 32'd0;
        alu_operand_b_o = (state_q == CALC) ? divisor_q : 32'd0;
    end

    // Next-state and datapath update for the whole sequencer
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        divisor_d  = divisor_q;
        dividend_d = dividend_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        ready_d    = ready_q;
        valid_d    = 1'b0;
        result_d   = result_q;

        case (state_q)
            IDLE: begin
                // A coincident kill (pipeline flush) cancels the start request
                if (div_en_i && !kill_i) begin
                    op_d       = div_op_i;
                    quot_d     = abs_a;
                    rem_d      = 32'd0;
                    divisor_d  = abs_b;
                    dividend_d = op_a_i;
                    neg_quot_d = start_signed & (op_a_i[31] ^ op_b_i[31]);
                    neg_rem_d  = start_signed & op_a_i[31];
                    div_zero_d = b_is_zero;
                    cnt_d      = 5'd31;
                    ready_d    = 1'b0;
                    if (b_is_zero && (ZERO_DIV_FAST != 0)) begin
                        result_d = div_op_i[1] ? op_a_i : 32'hFFFF_FFFF;
                        valid_d  = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                rem_d  = no_borrow ? alu_adder_result_i : shifted;
                quot_d = {quot_q[30:0], no_borrow};
                if (cnt_q == 5'd0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            FIX: begin
                if (div_zero_q) begin
                    result_d = op_q[1] ? dividend_q : 32'hFFFF_FFFF;
                end else begin
                    result_d = op_q[1] ? rem_fixed : quot_fixed;
                end
                valid_d = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase

        // Flush: abandon the operation, keep the previously delivered result
        if (kill_i && (state_q != IDLE)) begin
            state_d  = IDLE;
            ready_d  = 1'b1;
            valid_d  = 1'b0;
            result_d = result_q;
        end
    end

    // State registers with synchronous reset that overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            op_q       <= 2'd0;
            quot_q     <= 32'd0;
            rem_q      <= 32'd0;
            divisor_q  <= 32'd0;
            dividend_q <= 32'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            result_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            divisor_q  <= divisor_d;
            dividend_q <= dividend_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            result_q   <= result_d;
        end
    end

    // A flush arriving in the DONE cycle still hides the pulse
    always_comb begin
        ready_o  = ready_q;
        valid_o  = valid_q & ~kill_i;
        result_o = result_q;
    end

endmodule

// File: tb/tb_zeroriscy_div_seq.sv
// Scoreboard bench for zeroriscy_div_seq: directed vectors, expected results queued at issue.
// Two instances: fast divide-by-zero (main) and full-sequence divide-by-zero.
// Each instance gets its own combinational ALU model.
module tb_zeroriscy_div_seq;

    localparam int               OPW     = 6;
    localparam logic [OPW-1:0]   OP_ADD  = 6'd24;
    localparam logic [OPW-1:0]   OP_SUB  = 6'd25;

    localparam logic [1:0] DIV  = 2'b00;
    localparam logic [1:0] DIVU = 2'b01;
    localparam logic [1:0] REM  = 2'b10;
    localparam logic [1:0] REMU = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        div_en = 1'b0;
    logic        div_en_s = 1'b0;
    logic [1:0]  div_op = 2'b00;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        kill = 1'b0;

    logic           ready_f, valid_f, req_f;
    logic [31:0]    result_f, opa_f, opb_f, addr_f;
    logic [OPW-1:0] oper_f;
    logic           ready_s, valid_s, req_s;
    logic [31:0]    result_s, opa_s, opb_s, addr_s;
    logic [OPW-1:0] oper_s;

    assign addr_f = (oper_f == OP_SUB) ? (opa_f - opb_f) : (opa_f + opb_f);
    assign addr_s = (oper_s == OP_SUB) ? (opa_s - opb_s) : (opa_s + opb_s);

    zeroriscy_div_seq #(.ZERO_DIV_FAST(1), .ALU_OP_WIDTH(OPW), .ALU_ADD(OP_ADD), .ALU_SUB(OP_SUB)) dut (
        .clk(clk), .rst(rst), .div_en_i(div_en), .div_op_i(div_op), .op_a_i(op_a), .op_b_i(op_b),
        .kill_i(kill), .ready_o(ready_f), .valid_o(valid_f), .result_o(result_f),
        .alu_req_o(req_f), .alu_operator_o(oper_f), .alu_operand_a_o(opa_f),
        .alu_operand_b_o(opb_f), .alu_adder_result_i(addr_f)
    );

    zeroriscy_div_seq #(.ZERO_DIV_FAST(0), .ALU_OP_WIDTH(OPW), .ALU_ADD(OP_ADD), .ALU_SUB(OP_SUB)) dut_slow (
        .clk(clk), .rst(rst), .div_en_i(div_en_s), .div_op_i(div_op), .op_a_i(op_a), .op_b_i(op_b),
        .kill_i(kill), .ready_o(ready_s), .valid_o(valid_s), .result_o(result_s),
        .alu_req_o(req_s), .alu_operator_o(oper_s), .alu_operand_a_o(opa_s),
        .alu_operand_b_o(opb_s), .alu_adder_result_i(addr_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        int          id;
    } exp_t;

    exp_t exp_qf[$];
    exp_t exp_qs[$];

    int cyc = 0;
    int chk_cnt = 0;
    int pass_cnt = 0;
    int req_cnt = 0;
    int req_first = -1;
    int req_last = -1;
    int vec_id = 0;
    logic [31:0] last_res = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, req, cyc);
    endtask

    task automatic fail_now(input string nm);
        chk_cnt++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Monitor for the fast instance: pop and compare on every valid pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (req_f) begin
                req_cnt++;
                if (req_first < 0) req_first = cyc;
                req_last = cyc;
            end
            if (valid_f) begin
                if (exp_qf.size() == 0) begin
                    fail_now("fast_unexpected_valid");
                end else begin
                    e = exp_qf.pop_front();
                    chk($sformatf("fast_result_v%0d", e.id), result_f, e.res);
                    chk($sformatf("fast_valid_cycle_v%0d", e.id), 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    // Monitor for the full-sequence instance
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid_s) begin
                if (exp_qs.size() == 0) begin
                    fail_now("slow_unexpected_valid");
                end else begin
                    e = exp_qs.pop_front();
                    chk($sformatf("slow_result_v%0d", e.id), result_s, e.res);
                    chk($sformatf("slow_valid_cycle_v%0d", e.id), 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for ready, pulse the start for one cycle, optionally queue the expectation
    task automatic issue(input bit slow, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit push, input logic [31:0] res,
                         input int lat, output int c0);
        exp_t e;
        int n;
        n = 0;
        while (!(slow ? ready_s : ready_f) && n < 200) begin
            step();
            n++;
        end
        if (!(slow ? ready_s : ready_f)) fail_now("ready_timeout");
        div_op = op;
        op_a = a;
        op_b = b;
        if (slow) div_en_s = 1'b1;
        else div_en = 1'b1;
        c0 = cyc;
        if (push) begin
            vec_id++;
            e.res = res;
            e.cyc = c0 + lat;
            e.id = vec_id;
            if (slow) exp_qs.push_back(e);
            else begin
                exp_qf.push_back(e);
                last_res = res;
            end
        end
        step();
        div_en = 1'b0;
        div_en_s = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_qf.size() != 0 || exp_qs.size() != 0) && n < 100) begin
            step();
            n++;
        end
        if (exp_qf.size() != 0 || exp_qs.size() != 0) begin
            fail_now("valid_timeout");
            exp_qf.delete();
            exp_qs.delete();
        end
    endtask

    task automatic run(input bit slow, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input int lat);
        int c0;
        issue(slow, op, a, b, 1'b1, res, lat, c0);
        drain();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("reset_ready", 32'(ready_f), 32'd1);
        chk("reset_valid", 32'(valid_f), 32'd0);
        chk("reset_result", result_f, 32'd0);
        chk("reset_alu_req", 32'(req_f), 32'd0);
        chk("reset_alu_operand_a", opa_f, 32'd0);

        // Basic unsigned, with ALU ownership window
        req_cnt = 0;
        req_first = -1;
        req_last = -1;
        issue(1'b0, DIVU, 32'd100, 32'd7, 1'b1, 32'd14, 34, c0);
        drain();
        chk("alu_req_count", 32'(req_cnt), 32'd32);
        chk("alu_req_first", 32'(req_first), 32'(c0 + 1));
        chk("alu_req_last", 32'(req_last), 32'(c0 + 32));
        run(1'b0, REMU, 32'd100, 32'd7, 32'd2, 34);

        // Signed quotient/remainder sign handling
        run(1'b0, DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run(1'b0, REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run(1'b0, DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
        run(1'b0, REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);

        // Boundaries: signed overflow, max dividend, forced subtract path
        run(1'b0, DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
        run(1'b0, REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);
        run(1'b0, DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);
        run(1'b0, DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 34);
        run(1'b0, REMU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 34);

        // Divide by zero, fast bypass
        run(1'b0, DIV, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1);
        run(1'b0, REM, 32'h0000_1234, 32'd0, 32'h0000_1234, 1);
        run(1'b0, DIVU, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1);
        run(1'b0, REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);

        // Divide by zero, full sequence
        run(1'b1, DIV, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 34);
        run(1'b1, REMU, 32'h0000_1234, 32'd0, 32'h0000_1234, 34);
        run(1'b1, DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 34);
        run(1'b1, REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 34);

        // Kill mid-calculation: no valid, result kept, then a fresh operation
        issue(1'b0, DIVU, 32'd1000, 32'd7, 1'b0, 32'd0, 0, c0);
        while (cyc < c0 + 10) step();
        kill = 1'b1;
        step();
        kill = 1'b0;
        chk("kill_ready", 32'(ready_f), 32'd1);
        chk("kill_result_kept", result_f, last_res);
        chk("kill_alu_req", 32'(req_f), 32'd0);
        repeat (40) step();
        run(1'b0, DIVU, 32'd9, 32'd3, 32'd3, 34);

        // Reset during calculation
        issue(1'b0, DIV, 32'd12345, 32'd17, 1'b0, 32'd0, 0, c0);
        while (cyc < c0 + 20) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_ready", 32'(ready_f), 32'd1);
        chk("midrst_valid", 32'(valid_f), 32'd0);
        chk("midrst_result", result_f, 32'd0);
        chk("midrst_alu_req", 32'(req_f), 32'd0);
        repeat (40) step();

        // Start request during calculation is ignored
        issue(1'b0, DIVU, 32'd100, 32'd7, 1'b1, 32'd14, 34, c0);
        while (cyc < c0 + 5) step();
        div_op = DIV;
        op_a = 32'd50;
        op_b = 32'd5;
        div_en = 1'b1;
        step();
        div_en = 1'b0;
        drain();
        repeat (5) step();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
